// File: rtl/disp_scan32_pkg.sv
// Shared constants for the 8-digit multiplexed seven-segment scanner.
package disp_scan32_pkg;

  localparam int NUM_DIGITS = 8;

  // Active-low segment codes {dp,g,f,e,d,c,b,a}, decimal point off.
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  // All segments dark / no digit selected.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder (no dp).
module hex7seg
  import disp_scan32_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg7
);

  // Table lookup of the segment pattern for one hex digit.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    seg7 = SEG_BLANK[6:0];
    case (nibble)
      4'h0: seg7 = SEG_0[6:0];
      4'h1: seg7 = SEG_1[6:0];
      4'h2: seg7 = SEG_2[6:0];
      4'h3: seg7 = SEG_3[6:0];
      4'h4: seg7 = SEG_4[6:0];
      4'h5: seg7 = SEG_5[6:0];
      4'h6: seg7 = SEG_6[6:0];
      4'h7: seg7 = SEG_7[6:0];
      4'h8: seg7 = SEG_8[6:0];
      4'h9: seg7 = SEG_9[6:0];
      4'hA: seg7 = SEG_A[6:0];
      4'hB: seg7 = SEG_B[6:0];
      4'hC: seg7 = SEG_C[6:0];
      4'hD: seg7 = SEG_D[6:0];
      4'hE: seg7 = SEG_E[6:0];
      4'hF: seg7 = SEG_F[6:0];
      default: seg7 = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/disp_scan32.sv
// 8-digit multiplexed hex display scanner with per-frame input snapshot,
// per-digit blink and decimal points. Outputs are registered, active-low.
module disp_scan32
  import disp_scan32_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [31:0]           data,
  input  logic [NUM_DIGITS-1:0] blink,
  input  logic [NUM_DIGITS-1:0] point,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            seg
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]         pcnt;
  logic [2:0]            idx;
  logic [FW-1:0]         fcnt;
  logic                  phase;

  logic [31:0]           snap_data;
  logic [NUM_DIGITS-1:0] snap_blink;
  logic [NUM_DIGITS-1:0] snap_point;

  logic                  tick;
  logic                  frame_wrap;
  logic                  last_frame;
  logic                  snap_load;

  logic [31:0]           cur_data;
  logic [NUM_DIGITS-1:0] cur_blink;
  logic [NUM_DIGITS-1:0] cur_point;
  logic [3:0]            nibble;
  logic [6:0]            hex_seg;
  logic                  blank;
  logic                  dp_on;
  logic [NUM_DIGITS-1:0] an_next;
  logic [7:0]            seg_next;

  assign tick       = (pcnt == PW'(SCAN_DIV - 1));
  assign frame_wrap = tick && (idx == 3'd7);
  assign last_frame = (fcnt == FW'(BLINK_FRAMES - 1));
  assign snap_load  = (pcnt == '0) && (idx == 3'd0);

  // Free-running prescaler, digit index, frame counter and blink phase.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      pcnt  <= '0;
      idx   <= 3'd0;
      fcnt  <= '0;
      phase <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) idx <= idx + 3'd1;
      if (frame_wrap) begin
        if (last_frame) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  // Capture the inputs once per frame so a frame never mixes old and new values.
  always_ff @(posedge clk) begin
    // NOTE: these are a handful of flops, not a memory array, so they take an explicit reset value.
    if (!rst_n) begin
      snap_data  <= '0;
      snap_blink <= '0;
      snap_point <= '0;
    end else if (snap_load) begin
      snap_data  <= data;
      snap_blink <= blink;
      snap_point <= point;
    end
  end

  // The digit-0 output of a frame is computed on the load cycle itself, so it
  // takes the value being captured; all later digits read the held snapshot.
  always_comb begin
    cur_data  = snap_load ? data  : snap_data;
    cur_blink = snap_load ? blink : snap_blink;
    cur_point = snap_load ? point : snap_point;
    nibble    = cur_data[{idx, 2'b00} +: 4];
  end

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg7   (hex_seg)
  );

  // Anode select, blanking and decimal point for the current digit.
  always_comb begin
    blank    = cur_blink[idx] & phase;
    dp_on    = cur_point[idx] & ~blank;
    an_next  = AN_OFF;
    seg_next = SEG_BLANK;
    if (en) begin
      an_next  = ~(NUM_DIGITS'(1) << idx);
      seg_next = blank ? SEG_BLANK : {~dp_on, hex_seg};
    end
  end

  // Registered display drive, one cycle behind idx and snapshot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_disp_scan32.sv
// Directed self-checking bench for disp_scan32 with SCAN_DIV=4, BLINK_FRAMES=2.
// Timing reference: n counts clock edges since reset release; outputs sampled
// at the negedge after edge n reflect state cycle n-1, so digit k of frame f
// is visible for n = 32f+4k+1 .. 32f+4k+4.
module tb_disp_scan32;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] data;
  logic [7:0]  blink;
  logic [7:0]  point;
  logic [7:0]  an;
  logic [7:0]  seg;

  int n;
  int checks;
  int errors;

  logic [7:0] an_tab   [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  // Segments for data 32'h87654321, digits 0..7.
  logic [7:0] seg_8765 [8] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
  // Segments for data 32'h12345678, digits 0..3.
  logic [7:0] seg_1234 [4] = '{8'h80, 8'hF8, 8'h82, 8'h92};

  disp_scan32 #(
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .data  (data),
    .blink (blink),
    .point (point),
    .an    (an),
    .seg   (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    n = n + 1;
  endtask

  task automatic step_to(input int target);
    while (n < target) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    n = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    data  = 32'h8765_4321;
    blink = 8'h00;
    point = 8'h00;
    repeat (3) step();
    checks++;
    if (an !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h want %h", an, 8'hFF); end
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h want %h", seg, 8'hFF); end
    rst_n = 1'b1;
    n = 0;
    step();
    checks++;
    if (an !== 8'hFE) begin errors++; $display("FAIL release_an: got %h want %h", an, 8'hFE); end
    checks++;
    if (seg !== 8'hF9) begin errors++; $display("FAIL release_seg: got %h want %h", seg, 8'hF9); end
  endtask

  task automatic test_scan_order();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 8; k++) begin
        step_to(32 * f + 4 * k + 2);
        checks++;
        if (an !== an_tab[k]) begin
          errors++; $display("FAIL scan_an f%0d d%0d: got %h want %h", f, k, an, an_tab[k]);
        end
        checks++;
        if (seg !== seg_8765[k]) begin
          errors++; $display("FAIL scan_seg f%0d d%0d: got %h want %h", f, k, seg, seg_8765[k]);
        end
      end
    end
  endtask

  task automatic test_blink();
    logic [7:0] exp_seg;
    data  = 32'h8765_4321;
    blink = 8'h01;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      step_to(32 * f + 2);
      exp_seg = (f == 2 || f == 3) ? 8'hFF : 8'hF9;
      checks++;
      if (an !== 8'hFE) begin errors++; $display("FAIL blink_an f%0d: got %h want %h", f, an, 8'hFE); end
      checks++;
      if (seg !== exp_seg) begin
        errors++; $display("FAIL blink_seg f%0d: got %h want %h", f, seg, exp_seg);
      end
      if (f == 2) begin
        step_to(32 * f + 6);
        checks++;
        if (an !== 8'hFD) begin errors++; $display("FAIL blink_other_an: got %h want %h", an, 8'hFD); end
        checks++;
        if (seg !== 8'hA4) begin errors++; $display("FAIL blink_other_seg: got %h want %h", seg, 8'hA4); end
      end
    end
    blink = 8'h00;
  endtask

  task automatic test_snapshot();
    data = 32'h8765_4321;
    do_reset();
    step_to(13);
    data = 32'h1234_5678;
    for (int k = 4; k < 8; k++) begin
      step_to(4 * k + 2);
      checks++;
      if (seg !== seg_8765[k]) begin
        errors++; $display("FAIL snap_hold d%0d: got %h want %h", k, seg, seg_8765[k]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      step_to(32 + 4 * k + 2);
      checks++;
      if (seg !== seg_1234[k]) begin
        errors++; $display("FAIL snap_next d%0d: got %h want %h", k, seg, seg_1234[k]);
      end
    end
  endtask

  task automatic test_enable_dp();
    data  = 32'h8765_4321;
    point = 8'h80;
    do_reset();
    step_to(26);
    checks++;
    if (seg !== 8'hF8) begin errors++; $display("FAIL dp_d6_seg: got %h want %h", seg, 8'hF8); end
    step_to(30);
    checks++;
    if (an !== 8'h7F) begin errors++; $display("FAIL dp_d7_an: got %h want %h", an, 8'h7F); end
    checks++;
    if (seg !== 8'h00) begin errors++; $display("FAIL dp_d7_seg: got %h want %h", seg, 8'h00); end
    step_to(33);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (an !== 8'hFF) begin errors++; $display("FAIL en_off_an %0d: got %h want %h", i, an, 8'hFF); end
      checks++;
      if (seg !== 8'hFF) begin errors++; $display("FAIL en_off_seg %0d: got %h want %h", i, seg, 8'hFF); end
    end
    en = 1'b1;
    step();
    checks++;
    if (an !== 8'hFB) begin errors++; $display("FAIL en_resume_an: got %h want %h", an, 8'hFB); end
    checks++;
    if (seg !== 8'hB0) begin errors++; $display("FAIL en_resume_seg: got %h want %h", seg, 8'hB0); end
    step_to(46);
    checks++;
    if (an !== 8'hF7) begin errors++; $display("FAIL en_next_an: got %h want %h", an, 8'hF7); end
    checks++;
    if (seg !== 8'h99) begin errors++; $display("FAIL en_next_seg: got %h want %h", seg, 8'h99); end
    step_to(62);
    checks++;
    if (seg !== 8'h00) begin errors++; $display("FAIL dp_f1_seg: got %h want %h", seg, 8'h00); end
    point = 8'h00;
  endtask

  task automatic test_reset_midframe();
    data = 32'h8765_4321;
    do_reset();
    step_to(22);
    rst_n = 1'b0;
    data  = 32'h1234_5678;
    step();
    checks++;
    if (an !== 8'hFF) begin errors++; $display("FAIL mid_reset_an: got %h want %h", an, 8'hFF); end
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("FAIL mid_reset_seg: got %h want %h", seg, 8'hFF); end
    rst_n = 1'b1;
    n = 0;
    step();
    checks++;
    if (an !== 8'hFE) begin errors++; $display("FAIL mid_release_an: got %h want %h", an, 8'hFE); end
    checks++;
    if (seg !== 8'h80) begin errors++; $display("FAIL mid_release_seg: got %h want %h", seg, 8'h80); end
    step_to(6);
    checks++;
    if (an !== 8'hFD) begin errors++; $display("FAIL mid_d1_an: got %h want %h", an, 8'hFD); end
    checks++;
    if (seg !== 8'hF8) begin errors++; $display("FAIL mid_d1_seg: got %h want %h", seg, 8'hF8); end
  endtask

  initial begin
    n      = 0;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    data   = 32'h0;
    blink  = 8'h00;
    point  = 8'h00;
    test_reset();
    test_scan_order();
    test_blink();
    test_snapshot();
    test_enable_dp();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scan32.md
DISP_SCAN32 -- requirements
Module: disp_scan32

Interface
REQ-001 SCAN_DIV, default 50000, clock cycles each digit is driven; legal range >= 2.
REQ-002 BLINK_FRAMES, default 64, full 8-digit frames per blink half-period; legal range >= 1.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 en  input  1  display enable; 0 blanks all digits.
REQ-006 data  input  32  eight hex nibbles; data[4k+3:4k] is shown on digit k, with digit 0 rightmost.
REQ-007 blink  input  8  one-hot or multi-hot mask; bit k set means digit k blinks (the edit-cursor mask from the input editor).
REQ-008 point  input  8  bit k set lights the decimal point of digit k.
REQ-009 an  output  8  digit anodes, active-low; at most one bit is 0 at any time.
REQ-010 seg  output  8  segments, active-low; seg[7]=dp and seg[6:0]=g,f,e,d,c,b,a.

Function
REQ-011 Prescaler pcnt counts 0..SCAN_DIV-1 and wraps to 0; a tick is the cycle with pcnt==SCAN_DIV-1.
REQ-012 Digit index idx (3 bits) increments on each tick and wraps 7->0.
REQ-013 A frame wrap is a tick with idx==7.
REQ-014 Snapshot registers for data, blink and point load in every cycle with pcnt==0 and idx==0; the frame displays only snapshot values, so there is no tearing mid-frame.
REQ-015 Frame counter fcnt counts frame wraps 0..BLINK_FRAMES-1; on the frame wrap where fcnt==BLINK_FRAMES-1, fcnt returns to 0 and phase toggles.
REQ-016 Digit k is blanked when snap_blink[k]==1 and phase==1; blanked means an bit still driven active and seg==8'hFF.
REQ-017 Hex decode, active-low with dp off: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 B=83 C=C6 D=A1 E=86 F=8E.
REQ-018 When snap_point[idx]==1 and the digit is not blanked, seg[7] is driven 0.
REQ-019 an and seg are registered, one cycle of latency after idx and snapshot.
REQ-020 Next-value equations:
- an <= ~(8'b1<<idx) when en==1, else 8'hFF.
- seg <= 8'hFF when en==0.
REQ-021 en does not stop pcnt, idx, fcnt or phase; it only gates the outputs.
REQ-022 Input changes mid-frame have no visible effect until the next snapshot load.

Reset
REQ-023 When rst_n==0 at a clock edge, the following take these values:
- pcnt=0, idx=0, fcnt=0, phase=0.
- snapshots=0.
- an=8'hFF, seg=8'hFF.
REQ-024 Reset mid-frame takes effect on that edge.
REQ-025 The first cycle after reset release has pcnt==0 and idx==0, so the snapshot loads immediately.

Structure
REQ-026 The shared package holds:
- NUM_DIGITS=8.
- the 16 segment-code constants.
- SEG_BLANK=8'hFF and AN_OFF=8'hFF.
REQ-027 Sub-module hex7seg is purely combinational: 4-bit nibble in, 7-bit active-low segments out; it is instantiated once.
REQ-028 All remaining logic is in disp_scan32, with a target of 120-250 lines.

Verification
REQ-029 All scenarios use SCAN_DIV=4 and BLINK_FRAMES=2.
REQ-030 Reset: hold rst_n=0 for 3 cycles -> an=FF and seg=FF; one cycle after release -> an=FE and seg shows digit 0 of data as latched at release.
REQ-031 Scan order: data=32'h87654321, blink=0, point=0, en=1 -> digits k=0..7 appear every 4 cycles with an=FE,FD,..,7F and seg=F9,A4,B0,99,92,82,F8,80, repeating every 32 cycles.
REQ-032 Blink: blink=8'h01 -> digit 0 shows F9 for 2 frames (64 cycles), then FF for 2 frames, with an=FE throughout; other digits are unaffected.
REQ-033 Snapshot: change data to 32'h12345678 while idx==3 -> remaining digits of the frame still show 87654321; the next frame shows 78,56,... with seg=80 at digit 0.
REQ-034 Enable/dp: point=8'h80 -> digit 7 seg=00; en=0 for 10 cycles -> an=FF and seg=FF, then en=1 resumes at the idx the free-running counter has reached, with no restart.
